// File: rtl/cla8_adder.sv
// 8-bit two-level carry-lookahead adder with registered sum and per-bit carry outputs.
module cla8_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic [7:0] carry
);

    localparam int unsigned W = 8;

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] c;
    logic [W-1:0] sum;
    logic         gg0;
    logic         gp0;
    logic         gg1;
    logic         gp1;

    // Bitwise propagate and generate terms.
    always_comb begin
        p = a ^ b;
        g = a & b;
    end

    // Group generate/propagate for the lower (3:0) and upper (7:4) nibbles.
    always_comb begin
        gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp0 = p[3] & p[2] & p[1] & p[0];
        gg1 = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
        gp1 = p[7] & p[6] & p[5] & p[4];
    end

    // Flat lookahead carries; the upper nibble is seeded by the group carry c[3].
    always_comb begin
        c    = '0;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = gg0 | (gp0 & ci);
        c[4] = g[4] | (p[4] & c[3]);
        c[5] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[3]);
        c[6] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[3]);
        c[7] = gg1 | (gp1 & gg0) | (gp1 & gp0 & ci);
    end

    // Sum bits: each propagate term xor the carry into that position.
    always_comb begin
        sum = p ^ {c[W-2:0], ci};
    end

    // Output registers; reset clears both vectors and wins over the add.
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            carry <= '0;
        end else begin
            s     <= sum;
            carry <= c;
        end
    end

endmodule

// File: tb/tb_cla8_adder.sv
// Self-checking bench for cla8_adder: directed vector table, corner sequences, random traffic.
module tb_cla8_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic [7:0] carry;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_s;
        logic [7:0] exp_carry;
    } vec_t;

    vec_t vecs[7];

    cla8_adder dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .carry (carry)
    );

    always #5 clk = ~clk;

    // Reference: sum from plain addition; carry[i] is the carry out of the (i+1)-bit slice sum.
    function automatic logic [15:0] ref_add(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] full;
        logic [7:0] cv_out;
        int unsigned mask;
        int unsigned part;
        full = 9'(av) + 9'(bv) + 9'(cv);
        cv_out = '0;
        for (int i = 0; i < 8; i++) begin
            mask = (32'd1 << (i + 1)) - 32'd1;
            part = (32'(av) & mask) + (32'(bv) & mask) + 32'(cv);
            cv_out[i] = part[i + 1];
        end
        return {cv_out, full[7:0]};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        rst = r;
        a   = av;
        b   = bv;
        ci  = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic        rr;
        int          rst_at;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'hFF};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 8'hFF};
        vecs[2] = '{8'h0F, 8'h01, 1'b0, 8'h10, 8'h0F};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 8'h00};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 8'h00};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 8'h7F};

        rst = 1'b1;
        a   = '0;
        b   = '0;
        ci  = 1'b0;

        // Reset held for two edges with all-ones operands, then released.
        apply(1'b1, 8'hFF, 8'hFF, 1'b1);
        check8("reset1_s", s, 8'h00);
        check8("reset1_carry", carry, 8'h00);
        apply(1'b1, 8'hFF, 8'hFF, 1'b1);
        check8("reset2_s", s, 8'h00);
        check8("reset2_carry", carry, 8'h00);
        apply(1'b0, 8'hFF, 8'hFF, 1'b1);
        check8("first_s", s, 8'hFF);
        check8("first_carry", carry, 8'hFF);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].ci);
            check8($sformatf("vec%0d_s", i), s, vecs[i].exp_s);
            check8($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
        end

        // Low-bit detail for FF+01+1.
        apply(1'b0, 8'hFF, 8'h01, 1'b1);
        check8("bit_s0", {7'b0, s[0]}, 8'h01);
        check8("bit_c0", {7'b0, carry[0]}, 8'h01);
        check8("bit_s1", {7'b0, s[1]}, 8'h00);
        check8("bit_c1", {7'b0, carry[1]}, 8'h01);

        // Reset mid-stream discards the in-flight add; next edge takes fresh operands.
        apply(1'b0, 8'h12, 8'h34, 1'b0);
        check8("pre_rst_s", s, 8'h46);
        apply(1'b1, 8'hFF, 8'hFF, 1'b1);
        check8("mid_rst_s", s, 8'h00);
        check8("mid_rst_carry", carry, 8'h00);
        apply(1'b0, 8'h03, 8'h05, 1'b0);
        check8("post_rst_s", s, 8'h08);
        check8("post_rst_carry", carry, 8'h07);

        // Back-to-back random operands with one reset pulse at a random cycle.
        rst_at = int'($urandom_range(100, 1100));
        for (int i = 0; i < 1200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rr = (i == rst_at);
            apply(rr, ra, rb, rc);
            exp = rr ? 16'h0000 : ref_add(ra, rb, rc);
            check8($sformatf("rnd%0d_s", i), s, exp[7:0]);
            check8($sformatf("rnd%0d_carry", i), carry, exp[15:8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
